// File: rtl/compare_sweep_checker.sv
// rtl/compare_sweep_checker.sv - sweeps all 16 2-bit operand pairs through an external comparator
// and counts vectors whose red/blue/green response differs from an ideal compare.
module compare_sweep_checker #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [1:0] a_out,
  output logic [1:0] b_out,
  input  logic       red_in,
  input  logic       blue_in,
  input  logic       green_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       first_err_valid,
  output logic [3:0] first_err_vec,
  output logic [2:0] first_err_rbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] idx;
  logic [3:0] settle_cnt;
  logic [2:0] exp_rbg;
  logic [2:0] obs_rbg;
  logic       mismatch;

  assign a_out    = idx[3:2];
  assign b_out    = idx[1:0];
  assign exp_rbg  = {a_out > b_out, a_out < b_out, a_out == b_out};
  assign obs_rbg  = {red_in, blue_in, green_in};
  assign mismatch = (obs_rbg != exp_rbg);

  assign busy = (state == DRIVE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (err_count == 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= 4'd0;
      settle_cnt      <= 4'd0;
      err_count       <= 5'd0;
      first_err_valid <= 1'b0;
      first_err_vec   <= 4'd0;
      first_err_rbg   <= 3'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE holds its results until a new start clears them
          if (start) begin
            state           <= DRIVE;
            idx             <= 4'd0;
            settle_cnt      <= 4'd0;
            err_count       <= 5'd0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 4'd0;
            first_err_rbg   <= 3'd0;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 5'd1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= idx;
              first_err_rbg   <= obs_rbg;
            end
          end
          if (idx == 4'd15) begin
            state <= DONE;
          end else begin
            idx        <= idx + 4'd1;
            settle_cnt <= 4'd0;
            state      <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compare_sweep_checker.sv
// tb/tb_compare_sweep_checker.sv - bench for compare_sweep_checker with a table-driven comparator model.
module tb_compare_sweep_checker;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err;
    logic       fv;
    logic [3:0] vec;
    logic [2:0] rbg;
    logic [1:0] a;
    logic [1:0] b;
  } obs_t;

  typedef struct {
    int mode;
    int err;
    int fv;
    int vec;
    int rbg;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, start3;
  logic [1:0] a1, b1, a3, b3;
  logic       red1, blue1, green1, red3, blue3, green3;
  logic       busy1, done1, pass1, fv1, busy3, done3, pass3, fv3;
  logic [4:0] err1, err3;
  logic [3:0] vec1, vec3;
  logic [2:0] rbg1, rbg3;
  logic [2:0] resp [16];
  obs_t       obs1, obs3;

  int tests = 0;
  int fails = 0;

  compare_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1),
    .red_in(red1), .blue_in(blue1), .green_in(green1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fv1), .first_err_vec(vec1), .first_err_rbg(rbg1)
  );

  compare_sweep_checker #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_out(a3), .b_out(b3),
    .red_in(red3), .blue_in(blue3), .green_in(green3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_valid(fv3), .first_err_vec(vec3), .first_err_rbg(rbg3)
  );

  // the comparator under test is a lookup of whatever response each test loads
  assign {red1, blue1, green1} = resp[{a1, b1}];
  assign {red3, blue3, green3} = resp[{a3, b3}];
  assign obs1 = {busy1, done1, pass1, err1, fv1, vec1, rbg1, a1, b1};
  assign obs3 = {busy3, done3, pass3, err3, fv3, vec3, rbg3, a3, b3};

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic obs_t get(input int sel);
    return (sel != 0) ? obs3 : obs1;
  endfunction

  function automatic logic [2:0] ideal(input int v);
    int a, b;
    logic [2:0] r;
    a = v / 4;
    b = v % 4;
    r[2] = (a > b);
    r[1] = (a < b);
    r[0] = (a == b);
    return r;
  endfunction

  // 0 ideal, 1 green stuck low, 2 red/blue swapped, 3 random corruption
  task automatic fill(input int mode);
    logic [2:0] i;
    for (int v = 0; v < 16; v++) begin
      i = ideal(v);
      case (mode)
        1:       resp[v] = {i[2], i[1], 1'b0};
        2:       resp[v] = {i[1], i[2], i[0]};
        3:       resp[v] = ($urandom_range(0, 2) == 0) ? 3'($urandom) : i;
        default: resp[v] = i;
      endcase
    end
  endtask

  task automatic model(output int e_err, output int e_fv, output int e_vec, output int e_rbg);
    e_err = 0; e_fv = 0; e_vec = 0; e_rbg = 0;
    for (int v = 0; v < 16; v++) begin
      if (resp[v] != ideal(v)) begin
        if (e_fv == 0) begin
          e_fv = 1;
          e_vec = v;
          e_rbg = int'(resp[v]);
        end
        e_err++;
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start3 = v;
    else start1 = v;
  endtask

  task automatic run_sweep(input int sel, input int settle, input bit toggle, input bit pre_accepted);
    obs_t o;
    int   n, k, bad_busy, bad_hold;
    if (!pre_accepted) begin
      set_start(sel, 1'b1);
      tick;
    end
    set_start(sel, 1'b0);
    n = 16 * (settle + 1);
    k = 0;
    bad_busy = 0;
    bad_hold = 0;
    o = get(sel);
    check("accept_clears_results", int'(o.err) + int'(o.fv) + int'(o.vec) + int'(o.rbg), 0);
    while (!o.done && k < n + 8) begin
      if (o.busy !== 1'b1) bad_busy++;
      if (int'({o.a, o.b}) != k / (settle + 1)) bad_hold++;
      if (toggle) set_start(sel, 1'($urandom));
      tick;
      k++;
      o = get(sel);
    end
    set_start(sel, 1'b0);
    check("done_latency", k, n);
    check("busy_during_sweep", bad_busy, 0);
    check("vector_hold", bad_hold, 0);
    check("busy_low_in_done", int'(o.busy), 0);
  endtask

  task automatic check_results(input int sel, input int e_err, input int e_fv, input int e_vec, input int e_rbg);
    obs_t o, o2;
    o = get(sel);
    check("done", int'(o.done), 1);
    check("err_count", int'(o.err), e_err);
    check("pass", int'(o.pass), (e_err == 0) ? 1 : 0);
    check("first_err_valid", int'(o.fv), e_fv);
    check("first_err_vec", int'(o.vec), e_vec);
    check("first_err_rbg", int'(o.rbg), e_rbg);
    tick;
    tick;
    o2 = get(sel);
    check("done_held_stable", int'(o2), int'(o));
  endtask

  vec_t tbl[3];
  int   e_err, e_fv, e_vec, e_rbg;
  obs_t o;

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0};
    tbl[1] = '{1, 4, 1, 0, 0};
    tbl[2] = '{2, 12, 1, 1, 4};

    rst = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    fill(0);
    #2;
    check("reset_state_s1", int'(obs1), 0);
    check("reset_state_s3", int'(obs3), 0);
    tick;
    rst = 1'b0;
    tick;
    check("idle_no_start", int'(obs1), 0);

    for (int t = 0; t < 3; t++) begin
      fill(tbl[t].mode);
      run_sweep(0, 1, 1'b0, 1'b0);
      check_results(0, tbl[t].err, tbl[t].fv, tbl[t].vec, tbl[t].rbg);
    end

    // start toggling while busy must not disturb timing or results
    fill(0);
    run_sweep(0, 1, 1'b1, 1'b0);
    check_results(0, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      fill(3);
      model(e_err, e_fv, e_vec, e_rbg);
      run_sweep(0, 1, 1'($urandom), 1'b0);
      check_results(0, e_err, e_fv, e_vec, e_rbg);
    end

    // asynchronous reset mid-sweep at vector 7
    fill(1);
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int k = 0; k < 14; k++) tick;
    o = obs1;
    check("mid_sweep_idx", int'({o.a, o.b}), 7);
    check("mid_sweep_err", int'(o.err), 2);
    #2 rst = 1'b1;
    #1 check("async_reset_clears", int'(obs1), 0);
    #1 rst = 1'b0;
    fill(0);
    run_sweep(0, 1, 1'b0, 1'b0);
    check_results(0, 0, 0, 0, 0);

    // start held through reset is taken on the first edge after release
    fill(2);
    rst = 1'b1;
    start1 = 1'b1;
    tick;
    tick;
    check("busy_low_in_reset", int'(busy1), 0);
    rst = 1'b0;
    tick;
    check("start_after_reset_accepted", int'(busy1), 1);
    run_sweep(0, 1, 1'b0, 1'b1);
    check_results(0, 12, 1, 1, 4);

    // longer settle, restart from DONE after a failing sweep
    fill(1);
    run_sweep(1, 3, 1'b0, 1'b0);
    check_results(1, 4, 1, 0, 0);
    fill(0);
    run_sweep(1, 3, 1'b0, 1'b0);
    check_results(1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
